cache_refill_ctrl: RTL and testbench

- Miss/refill and write-through controller between the CPU memory stage, the 4-word direct-mapped write-noallocate cache, and a 32-bit main-memory port.
- On a read miss, fetches the 128-bit line as 4 word reads, then drives the cache install strobe (bwe/bdata).
- Every store is forwarded to memory. The cache updates itself only on a store hit.
- Stalls the core until the cache can return valid data or memory has accepted the store.

---
 rtl/cache_refill_ctrl.sv | 114 +++++++++++
 tb/tb_cache_refill_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - read-miss line refill and write-through controller
module cache_refill_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req,
  input  logic                     i_we,
  input  logic [ADDR_WIDTH-1:0]    i_addr,
  input  logic [31:0]              i_wdata,
  input  logic                     i_hit,
  output logic                     o_stall,
  output logic                     o_bwe,
  output logic [LINE_WORDS*32-1:0] o_bdata,
  output logic                     o_mem_req,
  output logic                     o_mem_we,
  output logic [ADDR_WIDTH-1:0]    o_mem_addr,
  output logic [31:0]              o_mem_wdata,
  input  logic                     i_mem_ack,
  input  logic [31:0]              i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    INSTALL = 2'd2,
    WRITE   = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(15);

  state_e                    state_q;
  logic [1:0]                cnt_q;
  logic [LINE_WORDS*32-1:0]  buf_q;
  logic                      bwe_q;
  logic                      mem_req_q;
  logic                      mem_we_q;
  logic [ADDR_WIDTH-1:0]     mem_addr_q;
  logic [31:0]               mem_wdata_q;

  // o_mem_addr doubles as the latched line/word address for both FILL and WRITE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      buf_q       <= '0;
      bwe_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          bwe_q <= 1'b0;
          if (i_req && i_we) begin
            state_q     <= WRITE;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= i_addr & WORD_MASK;
            mem_wdata_q <= i_wdata;
          end else if (i_req && !i_hit) begin
            state_q    <= FILL;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= i_addr & LINE_MASK;
            cnt_q      <= 2'd0;
          end
        end
        FILL: begin
          if (i_mem_ack) begin
            buf_q[{cnt_q, 5'b0} +: 32] <= i_mem_rdata;
            cnt_q                      <= cnt_q + 2'd1;
            mem_addr_q                 <= {mem_addr_q[ADDR_WIDTH-1:4], cnt_q + 2'd1, 2'b00};
            if (cnt_q == 2'd3) begin
              state_q   <= INSTALL;
              mem_req_q <= 1'b0;
              bwe_q     <= 1'b1;
            end
          end
        end
        INSTALL: begin
          bwe_q   <= 1'b0;
          state_q <= IDLE;
        end
        WRITE: begin
          if (i_mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          bwe_q     <= 1'b0;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  // After INSTALL the cache reports a hit, so the stall drops without extra state.
  assign o_stall     = i_rst_n & ((state_q != IDLE) | (i_req & (i_we | ~i_hit)));
  assign o_bwe       = bwe_q;
  assign o_bdata     = buf_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - self-checking bench for cache_refill_ctrl
module tb_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req, we, hit;
  logic [31:0]  addr, wdata;
  logic         stall, bwe, mem_req, mem_we, mem_ack;
  logic [127:0] bdata;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  cache_refill_ctrl #(.ADDR_WIDTH(32), .LINE_WORDS(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_we        (we),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .i_hit       (hit),
    .o_stall     (stall),
    .o_bwe       (bwe),
    .o_bdata     (bdata),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_ack   (mem_ack),
    .i_mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: the line is whatever memory returned on ack cycles, word n at the line base + 4n.
  task automatic read_miss(input logic [31:0] a, input int gap, input bit fixed_data);
    logic [127:0] exp_line;
    logic [31:0]  base;
    logic [31:0]  d;
    logic         ack;
    int acks, since, cyc, stalls;
    exp_line = '0;
    base     = a & 32'hFFFF_FFF0;
    acks = 0; since = 0; cyc = 0; stalls = 0;
    req = 1'b1; we = 1'b0; addr = a; hit = 1'b0; mem_ack = 1'b0;
    #4;
    chk("miss_detect_stall", stall, 1);
    chk("miss_detect_memreq", mem_req, 0);
    stalls += int'(stall);
    tick();
    while (acks < 4 && cyc < 200) begin
      ack = (gap < 0) ? 1'($urandom_range(0, 1)) : (since == gap);
      d   = fixed_data ? 32'hA0 + 32'(acks) : $urandom;
      mem_ack = ack; mem_rdata = d;
      #4;
      chk("fill_memreq", mem_req, 1);
      chk("fill_memwe", mem_we, 0);
      chk("fill_addr", mem_addr, base + 32'(acks * 4));
      chk("fill_bwe", bwe, 0);
      chk("fill_stall", stall, 1);
      stalls += int'(stall);
      if (ack) begin
        exp_line[acks*32 +: 32] = d;
        acks++;
        since = 0;
      end else begin
        since++;
      end
      cyc++;
      tick();
    end
    if (acks < 4) chk("fill_timeout", acks, 4);
    mem_ack = 1'b0;
    #4;
    chk("install_bwe", bwe, 1);
    chk("install_bdata", bdata, exp_line);
    chk("install_memreq", mem_req, 0);
    chk("install_stall", stall, 1);
    stalls += int'(stall);
    tick();
    hit = 1'b1;
    #4;
    chk("post_stall", stall, 0);
    chk("post_bwe", bwe, 0);
    chk("post_bdata_hold", bdata, exp_line);
    chk("miss_stall_cycles", stalls, cyc + 2);
    tick();
    req = 1'b0; hit = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input int delay, input logic h);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; hit = h; mem_ack = 1'b0;
    #4;
    chk("st_detect_stall", stall, 1);
    chk("st_detect_memreq", mem_req, 0);
    tick();
    for (int k = 0; k < delay; k++) begin
      mem_ack = (k == delay - 1);
      #4;
      chk("st_memreq", mem_req, 1);
      chk("st_memwe", mem_we, 1);
      chk("st_addr", mem_addr, {a[31:2], 2'b00});
      chk("st_wdata", mem_wdata, d);
      chk("st_stall", stall, 1);
      chk("st_bwe", bwe, 0);
      tick();
    end
    mem_ack = 1'b0; req = 1'b0; we = 1'b0; hit = 1'b0;
    #4;
    chk("st_after_stall", stall, 0);
    chk("st_after_memreq", mem_req, 0);
    chk("st_after_bwe", bwe, 0);
    tick();
  endtask

  task automatic hit_stream(input int n);
    for (int k = 0; k < n; k++) begin
      req = 1'b1; we = 1'b0; hit = 1'b1; addr = $urandom;
      #4;
      chk("hit_stall", stall, 0);
      chk("hit_memreq", mem_req, 0);
      chk("hit_bwe", bwe, 0);
      tick();
    end
    req = 1'b0; hit = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; hit = 1'b0; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_bwe", bwe, 0);
    chk("rst_memreq", mem_req, 0);
    chk("rst_memwe", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_bdata", bdata, 0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a fill, then stray acks must be ignored.
    req = 1'b1; we = 1'b0; hit = 1'b0; addr = 32'h0000_4000;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_rdata = 32'h2222_2222;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", stall, 0);
    chk("midrst_memreq", mem_req, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_bdata", bdata, 0);
    chk("midrst_bwe", bwe, 0);
    req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_ack = 1'b1;
      #4;
      chk("stray_memreq", mem_req, 0);
      chk("stray_bwe", bwe, 0);
      chk("stray_stall", stall, 0);
      tick();
    end
    mem_ack = 1'b0;

    read_miss(32'h0000_1234, 0, 1'b1);
    read_miss(32'h0000_5678, 2, 1'b0);
    store(32'h0000_2008, 32'hDEAD_BEEF, 5, 1'b1);
    store(32'h0000_200B, 32'h1234_5678, 1, 1'b0);
    hit_stream(10);
    read_miss(32'h0000_3010, 0, 1'b0);
    store(32'h0000_3014, 32'hCAFE_F00D, 2, 1'b1);

    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 2))
        0: read_miss($urandom, -1, 1'b0);
        1: store($urandom, $urandom, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
        default: hit_stream(3);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
